// File: rtl/fetch_stage.sv
// Instruction fetch stage: a PC register that drives the fetch address, plus one output register
// holding the fetched instruction and its PC for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        freeze,
  input  logic        misprediction,
  input  logic [31:0] correct_pc,
  input  logic [31:0] pc_prediction,
  input  logic [31:0] imemload,
  output logic [31:0] imemaddr,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  logic [31:0] r_pc_fetch;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        w_advance;
  logic [31:0] w_pc_next;

  assign w_advance = ihit & ~freeze;

  // A redirect always wins, even when the stage is stalled or the memory is missing.
  always_comb begin
    w_pc_next = r_pc_fetch;
    if (misprediction)
      w_pc_next = correct_pc;
    else if (w_advance)
      w_pc_next = pc_prediction;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_pc_fetch <= RESET_PC;
    else
      r_pc_fetch <= w_pc_next;
  end

  // The output register captures the current fetch regardless of a redirect, and a bubble otherwise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_instr  <= 32'h0;
      r_pc_out <= 32'h0;
    end else if (w_advance) begin
      r_instr  <= imemload;
      r_pc_out <= r_pc_fetch;
    end else begin
      r_instr  <= 32'h0;
      r_pc_out <= 32'h0;
    end
  end

  assign imemaddr = r_pc_fetch;
  assign instr    = r_instr;
  assign pc       = r_pc_out;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fixed stimulus steps whose expected outputs are written
// out by hand in the bench.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic        freeze;
  logic        misprediction;
  logic [31:0] correct_pc;
  logic [31:0] pc_prediction;
  logic [31:0] imemload;
  logic [31:0] imemaddr;
  logic [31:0] instr;
  logic [31:0] pc;

  int n_vec  = 0;
  int n_miss = 0;

  fetch_stage dut (
    .CLK          (CLK),
    .RST          (RST),
    .ihit         (ihit),
    .freeze       (freeze),
    .misprediction(misprediction),
    .correct_pc   (correct_pc),
    .pc_prediction(pc_prediction),
    .imemload     (imemload),
    .imemaddr     (imemaddr),
    .instr        (instr),
    .pc           (pc)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Step across n rising edges; inputs change and outputs are sampled on falling edges.
  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; freeze = 1'b0; misprediction = 1'b0;
    correct_pc = 32'h0; pc_prediction = 32'h0; imemload = 32'h0;
    #2;
    chk("rst_imemaddr", imemaddr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    cycles(2);
    RST = 1'b0;

    // Redirect on an advancing edge: the current fetch is still captured.
    ihit = 1'b1; misprediction = 1'b1; correct_pc = 32'hABCDEF01; imemload = 32'hACE1ACE1;
    cycles(1);
    chk("mp_first_instr", instr, 32'hACE1ACE1);
    chk("mp_first_pc", pc, 32'h0);
    chk("mp_first_addr", imemaddr, 32'hABCDEF01);
    cycles(5);
    chk("mp_instr", instr, 32'hACE1ACE1);
    chk("mp_pc", pc, 32'hABCDEF01);
    chk("mp_addr", imemaddr, 32'hABCDEF01);

    // Normal advance from the predictor.
    misprediction = 1'b0; pc_prediction = 32'hDEADBEEF; imemload = 32'hACE2ACE2;
    cycles(1);
    chk("adv_first_pc", pc, 32'hABCDEF01);
    chk("adv_first_addr", imemaddr, 32'hDEADBEEF);
    cycles(5);
    chk("adv_instr", instr, 32'hACE2ACE2);
    chk("adv_pc", pc, 32'hDEADBEEF);

    // Freeze: bubbles out, PC held.
    freeze = 1'b1; pc_prediction = 32'hAABBCCDD;
    cycles(6);
    chk("frz_instr", instr, 32'h0);
    chk("frz_pc", pc, 32'h0);
    chk("frz_addr", imemaddr, 32'hDEADBEEF);
    freeze = 1'b0;
    cycles(1);
    chk("unfrz_pc", pc, 32'hDEADBEEF);
    chk("unfrz_instr", instr, 32'hACE2ACE2);
    chk("unfrz_addr", imemaddr, 32'hAABBCCDD);

    // Instruction miss for three cycles, then resume without losing the held fetch.
    ihit = 1'b0; imemload = 32'h11112222; pc_prediction = 32'h33334444;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk("miss_instr", instr, 32'h0);
      chk("miss_pc", pc, 32'h0);
      chk("miss_addr", imemaddr, 32'hAABBCCDD);
    end
    ihit = 1'b1;
    cycles(1);
    chk("hit_instr", instr, 32'h11112222);
    chk("hit_pc", pc, 32'hAABBCCDD);
    chk("hit_addr", imemaddr, 32'h33334444);

    // Redirect while frozen: PC moves, outputs bubble.
    misprediction = 1'b1; freeze = 1'b1; correct_pc = 32'h55556666;
    cycles(1);
    chk("mpfrz_addr", imemaddr, 32'h55556666);
    chk("mpfrz_instr", instr, 32'h0);
    chk("mpfrz_pc", pc, 32'h0);

    // Load the output register, then reset asynchronously between edges.
    misprediction = 1'b0; freeze = 1'b0; imemload = 32'h77778888; pc_prediction = 32'h9999AAAA;
    cycles(1);
    chk("pre_rst_instr", instr, 32'h77778888);
    chk("pre_rst_pc", pc, 32'h55556666);
    chk("pre_rst_addr", imemaddr, 32'h9999AAAA);
    #1 RST = 1'b1;
    #1;
    chk("async_rst_addr", imemaddr, 32'h0);
    chk("async_rst_instr", instr, 32'h0);
    chk("async_rst_pc", pc, 32'h0);
    cycles(1);
    RST = 1'b0;
    imemload = 32'hCAFEF00D; pc_prediction = 32'h00000004;
    cycles(1);
    chk("resume_instr", instr, 32'hCAFEF00D);
    chk("resume_pc", pc, 32'h0);
    chk("resume_addr", imemaddr, 32'h00000004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-003 Port CLK  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-004 Port RST  input  1  SHALL be the asynchronous reset, active-high.
REQ-005 Port ihit  input  1  SHALL indicate that imemload is valid for the current imemaddr.
REQ-006 Port freeze  input  1  SHALL be the pipeline stall/freeze request from downstream.
REQ-007 Port misprediction  input  1  SHALL indicate that a branch was resolved as mispredicted.
REQ-008 Port correct_pc  input  32  SHALL be the redirect target, used when misprediction=1.
REQ-009 Port pc_prediction  input  32  SHALL be the predicted next PC from the predictor.
REQ-010 Port imemload  input  32  SHALL be the instruction word returned by instruction memory.
REQ-011 Port imemaddr  output  32  SHALL be the instruction fetch address, equal to the internal PC register.
REQ-012 Port instr  output  32  SHALL be the registered fetched instruction presented to decode.
REQ-013 Port pc  output  32  SHALL be the registered PC of instr presented to decode.

Function
REQ-014 The PC register SHALL drive imemaddr combinationally, with no extra latency.
REQ-015 The block SHALL compute advance = ihit AND NOT freeze.
REQ-016 When misprediction=1, the PC register SHALL load correct_pc on the edge, regardless of ihit and freeze; misprediction has top priority.
REQ-017 Else, when advance=1, the PC register SHALL load pc_prediction on the edge.
REQ-018 Otherwise (ihit=0 or freeze=1), the PC register SHALL hold its value.
REQ-019 On an edge with advance=1, the output register SHALL load instr<=imemload and pc<=current PC register value.
REQ-020 On an edge with advance=0, the output register SHALL load a bubble: instr=32'h0 and pc=32'h0.
REQ-021 A misprediction on an advancing edge SHALL still capture imemload into instr; the redirect affects only the next fetch address.
REQ-022 Latency SHALL be one cycle from an imemaddr/imemload pair to the matching instr/pc outputs.
REQ-023 All arithmetic SHALL be 32-bit with no internal PC+4 adder; the next PC SHALL come only from pc_prediction or correct_pc.
REQ-024 Simultaneous misprediction=1 and freeze=1 SHALL redirect the PC and emit a bubble on the outputs.

Reset
REQ-025 While RST=1, the block SHALL asynchronously force PC=RESET_PC, instr=0 and pc=0.
REQ-026 Deasserting RST SHALL resume operation on the next rising edge.
REQ-027 Asserting RST mid-stream SHALL immediately discard any in-flight fetch.

Verification
REQ-028 Scenario: reset, then RST=0, ihit=1, freeze=0, misprediction=1, correct_pc=ABCDEF01, imemload=ACE1ACE1, 6 cycles -> instr=ACE1ACE1, pc=ABCDEF01, imemaddr=ABCDEF01.
REQ-029 Scenario: from the prior state, misprediction=0, pc_prediction=DEADBEEF, imemload=ACE2ACE2, 6 cycles -> instr=ACE2ACE2, pc=DEADBEEF.
REQ-030 Scenario: freeze=1, pc_prediction=AABBCCDD, 6 cycles -> instr=0, pc=0, imemaddr held at DEADBEEF; after freeze=0, the next edge outputs pc=DEADBEEF.
REQ-031 Scenario: ihit=0 for 3 cycles -> bubbles on instr/pc and PC held; ihit=1 resumes with no lost instruction.
REQ-032 Scenario: misprediction=1 with freeze=1 -> PC=correct_pc after 1 edge and outputs=0.
REQ-033 Scenario: RST asserted mid-stream -> PC=0, instr=0 and pc=0 immediately, without waiting for a clock edge.
